toll_accumulator_mc: RTL and testbench

//  Multi-lane toll booth core for the DE2-115 toll design. Classifies each lane's vehicle
//  (axles, weight) into category 1/2/3/E, debounces-free edge-detects active-low charge

---
 rtl/toll_accumulator_mc_if.sv | 32 +++
 rtl/toll_accumulator_mc.sv | 210 +++++++++++++++++++++
 tb/tb_toll_accumulator_mc.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/toll_accumulator_mc_if.sv
// Lane inputs and accumulator status of the toll booth core, grouped for the board wrapper.
`timescale 1ns/1ps
interface toll_accumulator_mc_if #(
  parameter int LANES  = 2,
  parameter int DIGITS = 4,
  parameter int CNT_W  = 8
);
  logic                  clr;
  logic [2*LANES-1:0]    eixos;
  logic [4*LANES-1:0]    peso;
  logic [LANES-1:0]      key_n;
  logic [2*LANES-1:0]    cat;
  logic [8*LANES-1:0]    valor_bcd;
  logic [4*DIGITS-1:0]   total_bcd;
  logic [2:0]            grant;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  ovf;
  logic [CNT_W-1:0]      veh_cnt;
  logic [CNT_W-1:0]      err_cnt;

  modport master (
    output clr, eixos, peso, key_n,
    input  cat, valor_bcd, total_bcd, grant, busy, done, err, ovf, veh_cnt, err_cnt
  );

  modport slave (
    input  clr, eixos, peso, key_n,
    output cat, valor_bcd, total_bcd, grant, busy, done, err, ovf, veh_cnt, err_cnt
  );
endinterface

// File: rtl/toll_accumulator_mc.sv
// Multi-lane toll core: per-lane classification, key edge capture, round-robin grant
// and a digit-serial saturating BCD accumulator.
`timescale 1ns/1ps
module toll_accumulator_mc #(
  parameter int LANES  = 2,
  parameter int DIGITS = 4,
  parameter int CNT_W  = 8,
  parameter int LIM1   = 7,
  parameter int LIM2   = 12,
  parameter int TAR1   = 10,
  parameter int TAR2   = 25,
  parameter int TAR3   = 50
) (
  input logic            CLOCK_50,
  input logic            rst_n,
  toll_accumulator_mc_if.slave bus
);

  localparam int                IDX_W    = $clog2(DIGITS);
  localparam logic [IDX_W-1:0]  LAST     = IDX_W'(DIGITS - 1);
  localparam logic [3:0]        LIM1_W   = 4'(LIM1);
  localparam logic [3:0]        LIM2_W   = 4'(LIM2);
  localparam logic [7:0]        TAR1_BCD = {4'(TAR1 / 10), 4'(TAR1 % 10)};
  localparam logic [7:0]        TAR2_BCD = {4'(TAR2 / 10), 4'(TAR2 % 10)};
  localparam logic [7:0]        TAR3_BCD = {4'(TAR3 / 10), 4'(TAR3 % 10)};

  typedef enum logic {IDLE, ADD} state_t;

  state_t           state, state_n;
  logic [LANES-1:0] sync1, sync2, key_d, fall, pending, grant_mask;
  logic [1:0]       cat_arr [LANES];
  logic [3:0]       total [DIGITS];
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [7:0]       addend;
  logic [2:0]       grant;
  logic             done, err, ovf;
  logic [CNT_W-1:0] veh_cnt, err_cnt;

  logic             take, found_hi, found_lo;
  logic [2:0]       sel, hi_sel, lo_sel;
  logic [1:0]       sel_cat;
  logic [3:0]       add_dig, sum_dig;
  logic [4:0]       sum;
  logic             cout;

  function automatic logic [7:0] tariff(input logic [1:0] c);
    case (c)
      2'd1:    return TAR1_BCD;
      2'd2:    return TAR2_BCD;
      2'd3:    return TAR3_BCD;
      default: return 8'h00;
    endcase
  endfunction

  // NOTE: every output of a combinational block gets a default before any branch,
  // otherwise a missed path holds its old value and synthesis infers a latch.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      cat_arr[i] = 2'd0;
      if (bus.peso[4*i +: 4] <= LIM1_W && bus.eixos[2*i +: 2] == 2'd0)
        cat_arr[i] = 2'd1;
      else if (bus.peso[4*i +: 4] <= LIM2_W && bus.eixos[2*i +: 2] == 2'd1)
        cat_arr[i] = 2'd2;
      else if (bus.peso[4*i +: 4] > LIM2_W && bus.eixos[2*i +: 2] >= 2'd2)
        cat_arr[i] = 2'd3;
      bus.cat[2*i +: 2]       = cat_arr[i];
      bus.valor_bcd[8*i +: 8] = tariff(cat_arr[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser into one stage.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      key_d <= '1;
    end else begin
      sync1 <= bus.key_n;
      sync2 <= sync1;
      key_d <= sync2;
    end
  end

  assign fall = key_d & ~sync2;

  // A new edge re-sets pending even on the cycle its lane is granted.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)       pending <= '0;
    else if (bus.clr) pending <= '0;
    else              pending <= (pending & ~grant_mask) | fall;
  end

  always_comb begin
    state_n    = state;
    take       = 1'b0;
    found_hi   = 1'b0;
    found_lo   = 1'b0;
    hi_sel     = 3'd0;
    lo_sel     = 3'd0;
    sel_cat    = 2'd0;
    grant_mask = '0;
    // Lowest pending lane above the last grant wins, else lowest at or below it.
    for (int l = LANES - 1; l >= 0; l--) begin
      if (pending[l]) begin
        if (3'(l) > grant) begin hi_sel = 3'(l); found_hi = 1'b1; end
        else               begin lo_sel = 3'(l); found_lo = 1'b1; end
      end
    end
    sel = found_hi ? hi_sel : lo_sel;
    for (int l = 0; l < LANES; l++)
      if (3'(l) == sel) sel_cat = cat_arr[l];
    case (state)
      IDLE: if (found_hi || found_lo) begin
        take    = 1'b1;
        state_n = (sel_cat == 2'd0) ? IDLE : ADD;
      end
      ADD:  if (idx == LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.clr) begin
      take    = 1'b0;
      state_n = IDLE;
    end
    for (int l = 0; l < LANES; l++)
      if (take && 3'(l) == sel) grant_mask[l] = 1'b1;
  end

  always_comb begin
    add_dig = 4'd0;
    if (idx == IDX_W'(0))      add_dig = addend[3:0];
    else if (idx == IDX_W'(1)) add_dig = addend[7:4];
    sum     = {1'b0, total[idx]} + {1'b0, add_dig} + {4'd0, carry};
    cout    = (sum >= 5'd10);
    sum_dig = cout ? 4'(sum - 5'd10) : sum[3:0];
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // NOTE: the digit array is a handful of flops feeding the displays, so it is reset
  // like any other register rather than treated as an uninitialised memory.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < DIGITS; d++) total[d] <= 4'd0;
      idx     <= '0;
      carry   <= 1'b0;
      addend  <= 8'h00;
      grant   <= 3'd0;
      done    <= 1'b0;
      err     <= 1'b0;
      ovf     <= 1'b0;
      veh_cnt <= '0;
      err_cnt <= '0;
    end else if (bus.clr) begin
      for (int d = 0; d < DIGITS; d++) total[d] <= 4'd0;
      idx     <= '0;
      carry   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      ovf     <= 1'b0;
      veh_cnt <= '0;
      err_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (take) begin
        grant <= sel;
        if (sel_cat == 2'd0) begin
          err     <= 1'b1;
          err_cnt <= err_cnt + CNT_W'(1);
        end else begin
          addend <= tariff(sel_cat);
          idx    <= '0;
          carry  <= 1'b0;
        end
      end
      if (state == ADD) begin
        // Once saturated the total stays frozen at all-9s.
        if (!ovf) total[idx] <= sum_dig;
        carry <= cout;
        idx   <= idx + 1'b1;
        if (idx == LAST) begin
          done    <= 1'b1;
          veh_cnt <= veh_cnt + CNT_W'(1);
          if (cout) begin
            for (int d = 0; d < DIGITS; d++) total[d] <= 4'd9;
            ovf <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int d = 0; d < DIGITS; d++) bus.total_bcd[4*d +: 4] = total[d];
  end

  assign bus.grant   = grant;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done;
  assign bus.err     = err;
  assign bus.ovf     = ovf;
  assign bus.veh_cnt = veh_cnt;
  assign bus.err_cnt = err_cnt;

endmodule

// File: tb/tb_toll_accumulator_mc.sv
// Directed bench for toll_accumulator_mc: expected outcomes are queued per press and
// checked by an independent monitor whenever done or err pulses.
`timescale 1ns/1ps
module tb_toll_accumulator_mc;

  logic clk;
  logic rst_n;

  toll_accumulator_mc_if #(.LANES(2), .DIGITS(4), .CNT_W(8)) bus ();

  toll_accumulator_mc dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [2:0]  grant;
    logic [15:0] total;
    logic [7:0]  veh;
    logic [7:0]  errc;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  int         m_total;
  logic [7:0] m_veh, m_errc;
  logic       m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_clear();
    m_total = 0;
    m_veh   = 8'd0;
    m_errc  = 8'd0;
    m_ovf   = 1'b0;
  endtask

  // tar is the decimal tariff of the lane's category; 0 means category E.
  task automatic push_exp(input int lane, input int tar);
    exp_t e;
    if (tar == 0) begin
      m_errc = m_errc + 8'd1;
    end else begin
      m_veh = m_veh + 8'd1;
      if (m_total + tar > 9999) begin
        m_total = 9999;
        m_ovf   = 1'b1;
      end else begin
        m_total = m_total + tar;
      end
    end
    e.is_err = (tar == 0);
    e.grant  = 3'(lane);
    e.total  = to_bcd(m_total);
    e.veh    = m_veh;
    e.errc   = m_errc;
    e.ovf    = m_ovf;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.done || bus.err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, bus.done, bus.err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", {30'd0, bus.done, bus.err}, e.is_err ? 32'd1 : 32'd2);
        check("grant",      32'(bus.grant),     32'(e.grant));
        check("total",      32'(bus.total_bcd), 32'(e.total));
        check("veh_cnt",    32'(bus.veh_cnt),   32'(e.veh));
        check("err_cnt",    32'(bus.err_cnt),   32'(e.errc));
        check("ovf",        32'(bus.ovf),       32'(e.ovf));
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 32'(sb.size()) + 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] mask);
    @(negedge clk);
    bus.key_n = ~mask;
    repeat (3) @(negedge clk);
    bus.key_n = 2'b11;
    drain();
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    model_clear();
  endtask

  task automatic set_lanes(input logic [1:0] e1, input logic [3:0] p1,
                           input logic [1:0] e0, input logic [3:0] p0);
    bus.eixos = {e1, e0};
    bus.peso  = {p1, p0};
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int t_e [8] = '{0, 0, 1, 1, 2, 3, 2, 1};
  int t_p [8] = '{7, 8, 12, 13, 13, 15, 12, 0};
  int t_c [8] = '{1, 0, 2, 0, 3, 3, 0, 2};
  int t_v [8] = '{'h10, 'h00, 'h25, 'h00, 'h50, 'h50, 'h00, 'h25};

  initial begin
    rst_n     = 1'b0;
    bus.clr   = 1'b0;
    bus.key_n = 2'b11;
    bus.eixos = '0;
    bus.peso  = '0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_total",   32'(bus.total_bcd), 32'h0);
    check("rst_grant",   32'(bus.grant),     32'd0);
    check("rst_busy",    32'(bus.busy),      32'd0);
    check("rst_done",    32'(bus.done),      32'd0);
    check("rst_err",     32'(bus.err),       32'd0);
    check("rst_ovf",     32'(bus.ovf),       32'd0);
    check("rst_veh_cnt", 32'(bus.veh_cnt),   32'd0);
    check("rst_err_cnt", 32'(bus.err_cnt),   32'd0);

    // Classification boundaries on both lanes.
    for (int i = 0; i < 8; i++) begin
      set_lanes(2'(t_e[i]), 4'(t_p[i]), 2'(t_e[i]), 4'(t_p[i]));
      #1;
      check("cat_lane0",   32'(bus.cat[1:0]),        32'(t_c[i]));
      check("cat_lane1",   32'(bus.cat[3:2]),        32'(t_c[i]));
      check("valor_lane0", 32'(bus.valor_bcd[7:0]),  32'(t_v[i]));
      check("valor_lane1", 32'(bus.valor_bcd[15:8]), 32'(t_v[i]));
    end

    // Single cat-1 charge on lane 0.
    set_lanes(2'd1, 4'd12, 2'd0, 4'd5);
    push_exp(0, 10);
    press(2'b01);

    // Four cat-2 charges on lane 1: 25, 50, 75, 100.
    do_clr();
    for (int k = 0; k < 4; k++) begin
      push_exp(1, 25);
      press(2'b10);
    end
    check("total_after_4x25", 32'(bus.total_bcd), 32'h0100);

    // Simultaneous presses: last grant was lane 1, so lane 0 goes first.
    do_clr();
    set_lanes(2'd2, 4'd14, 2'd0, 4'd5);
    push_exp(0, 10);
    push_exp(1, 50);
    press(2'b11);
    check("total_both", 32'(bus.total_bcd), 32'h0060);

    // Category E on lane 0.
    do_clr();
    set_lanes(2'd2, 4'd14, 2'd2, 4'd3);
    push_exp(0, 0);
    press(2'b01);
    check("total_after_e", 32'(bus.total_bcd), 32'h0000);
    check("err_cnt_e",     32'(bus.err_cnt),   32'd1);
    check("veh_cnt_e",     32'(bus.veh_cnt),   32'd0);

    // Preload to 9990 = 199*50 + 4*10, then saturate.
    do_clr();
    set_lanes(2'd2, 4'd15, 2'd0, 4'd5);
    for (int k = 0; k < 199; k++) begin
      push_exp(1, 50);
      press(2'b10);
    end
    for (int k = 0; k < 4; k++) begin
      push_exp(0, 10);
      press(2'b01);
    end
    check("preload_total", 32'(bus.total_bcd), 32'h9990);
    check("preload_ovf",   32'(bus.ovf),       32'd0);
    push_exp(1, 50);
    press(2'b10);
    check("sat_total", 32'(bus.total_bcd), 32'h9999);
    check("sat_ovf",   32'(bus.ovf),       32'd1);
    push_exp(1, 50);
    press(2'b10);
    check("held_total", 32'(bus.total_bcd), 32'h9999);
    check("held_veh",   32'(bus.veh_cnt),   32'd205);

    // clr during the second ADD cycle aborts the charge.
    do_clr();
    set_lanes(2'd2, 4'd14, 2'd0, 4'd5);
    @(negedge clk);
    bus.key_n = 2'b10;
    begin
      int n;
      n = 0;
      while (!bus.busy && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("busy_timeout", 32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    model_clear();
    check("clr_busy",  32'(bus.busy),      32'd0);
    check("clr_total", 32'(bus.total_bcd), 32'h0000);
    check("clr_done",  32'(bus.done),      32'd0);
    bus.key_n = 2'b11;
    repeat (12) @(negedge clk);
    check("clr_total_late", 32'(bus.total_bcd), 32'h0000);
    check("clr_veh_cnt",    32'(bus.veh_cnt),   32'd0);
    check("clr_idle",       32'(bus.busy),      32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
